// File: rtl/imem_port.sv
// -----------------------------------------------------------------------------
// imem_port
//   Instruction-memory responder sitting on the far end of the fetch unit's
//   read port. A read request sampled at a clock edge returns
//   {mem_addr_out, mem_data_out} with mem_ready exactly LATENCY cycles later.
//   The pipeline accepts one request per cycle and keeps responses in order.
//   A write port loads the program. A flush kills every in-flight response
//   but still accepts the redirect request presented at the same edge.
//
//   Optional build macro: IMEM_STALL_INJECT_EN
//     When defined, a 16-bit LFSR raises mem_busy pseudo-randomly.
//     A request seen while mem_busy=1 is dropped.
//     When undefined, mem_busy is tied low.
//
// Ports
//   clk           clock, all state on posedge
//   rst_n         asynchronous active-low reset (pipeline only, not storage)
//   mem_re        read request
//   mem_raddr     read address (full width echoed back on mem_addr_out)
//   flush         kill all in-flight responses
//   mem_we        program-load write enable
//   mem_waddr     write address
//   mem_wdata     write data
//   mem_ready     response valid this cycle
//   mem_addr_out  address of the returned word
//   mem_data_out  returned instruction word
//   mem_busy      port not accepting this cycle
// -----------------------------------------------------------------------------
module imem_port #(
   parameter int    ADDR_W     = 16,
   parameter int    DATA_W     = 16,
   parameter int    DEPTH_LOG2 = 10,
   parameter int    LATENCY    = 1,   // legal range 1..4
   parameter string INIT_FILE  = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_re,
   input  logic [ADDR_W-1:0] mem_raddr,
   input  logic              flush,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_waddr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [DATA_W-1:0] mem_data_out,
   output logic              mem_busy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem    [DEPTH];
   logic                  vld_p  [LATENCY];
   logic [ADDR_W-1:0]     addr_p [LATENCY];
   logic [DATA_W-1:0]     data_p [LATENCY];

   logic                  accept;
   logic [DEPTH_LOG2-1:0] ridx;
   logic [DEPTH_LOG2-1:0] widx;

   // Upper address bits only alias onto the array; they are not needed for
   // the write index.
   logic                  unused_waddr_hi;
   assign unused_waddr_hi = ^mem_waddr[ADDR_W-1:DEPTH_LOG2];

   assign ridx   = mem_raddr[DEPTH_LOG2-1:0];
   assign widx   = mem_waddr[DEPTH_LOG2-1:0];
   assign accept = mem_re && !mem_busy;

   // Storage is never reset. The read in the pipeline block below samples
   // the pre-edge contents, so a same-edge read/write returns the old word.
   always_ff @(posedge clk) begin
      if (mem_we) mem[widx] <= mem_wdata;
   end

`ifdef IMEM_STALL_INJECT_EN
   logic [15:0] lfsr;
   logic        lfsr_fb;

   // Fibonacci taps 16,14,13,11
   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= 16'hACE1;
      else        lfsr <= {lfsr[14:0], lfsr_fb};
   end

   assign mem_busy = (lfsr[1:0] == 2'b00);
`else
   assign mem_busy = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LATENCY; k++) begin
            vld_p[k]  <= 1'b0;
            addr_p[k] <= '0;
            data_p[k] <= '0;
         end
      end else begin
         // stage 0: array read; a redirect arriving with flush still loads
         vld_p[0] <= accept;
         if (accept) begin
            addr_p[0] <= mem_raddr;
            data_p[0] <= mem[ridx];
         end
         // stages 1..LATENCY-1: shift, flush clears the in-flight valids
         for (int k = 1; k < LATENCY; k++) begin
            vld_p[k]  <= vld_p[k-1] && !flush;
            addr_p[k] <= addr_p[k-1];
            data_p[k] <= data_p[k-1];
         end
      end
   end

   assign mem_ready    = vld_p[LATENCY-1];
   assign mem_addr_out = addr_p[LATENCY-1];
   assign mem_data_out = data_p[LATENCY-1];

endmodule

// File: tb/tb_imem_port.sv
// -----------------------------------------------------------------------------
// tb_imem_port
//   Drives two imem_port instances (LATENCY=1 and LATENCY=3) from the same
//   inputs. A history-based reference model predicts every response:
//     - a request at edge s is returned in the cycle after edge s+L-1;
//     - it is lost if flush is seen at any edge in s+1..s+L-1;
//     - it is also lost if reset occurs after edge s.
//   Directed literal checks pin that model.
// -----------------------------------------------------------------------------
module tb_imem_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_re;
   logic [15:0] mem_raddr;
   logic        flush;
   logic        mem_we;
   logic [15:0] mem_waddr;
   logic [15:0] mem_wdata;

   logic        rdy1, busy1;
   logic [15:0] ao1, do1;
   logic        rdy3, busy3;
   logic [15:0] ao3, do3;

   int nvec = 0;
   int nbad = 0;

   always #5 clk = ~clk;

   imem_port #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .LATENCY(1), .INIT_FILE("")) u_dut1 (
      .clk(clk), .rst_n(rst_n), .mem_re(mem_re), .mem_raddr(mem_raddr), .flush(flush),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_ready(rdy1), .mem_addr_out(ao1), .mem_data_out(do1), .mem_busy(busy1));

   imem_port #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .LATENCY(3), .INIT_FILE("")) u_dut3 (
      .clk(clk), .rst_n(rst_n), .mem_re(mem_re), .mem_raddr(mem_raddr), .flush(flush),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_ready(rdy3), .mem_addr_out(ao3), .mem_data_out(do3), .mem_busy(busy3));

   // ---------------- reference model ----------------
   localparam int MAXE = 4096;
   logic        acc_h  [MAXE];
   logic [15:0] addr_h [MAXE];
   logic [15:0] data_h [MAXE];
   logic        fl_h   [MAXE];
   logic [15:0] ref_mem [1024];
   int          ec       = 0;   // edges recorded out of reset
   int          rst_edge = 0;   // first edge index after the latest reset
   logic [15:0] lfsr_m   = 16'hACE1;

   function automatic logic busy_of(input logic [15:0] s);
`ifdef IMEM_STALL_INJECT_EN
      return s[1:0] == 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic bit exp_vld(input int L, input int e);
      int src;
      src = e - L + 1;
      if (src < 0 || src < rst_edge) return 1'b0;
      if (!acc_h[src]) return 1'b0;
      for (int j = src + 1; j <= e; j++) if (fl_h[j]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   task automatic chk_port(input string nm, input int L, input int e,
                           input logic r, input logic [15:0] a, input logic [15:0] d);
      int src;
      src = e - L + 1;
      if (exp_vld(L, e)) begin
         chk({nm, ".ready"}, 32'(r), 32'd1);
         chk({nm, ".addr"},  32'(a), 32'(addr_h[src]));
         chk({nm, ".data"},  32'(d), 32'(data_h[src]));
      end else begin
         chk({nm, ".ready"}, 32'(r), 32'd0);
      end
   endtask

   // Record each edge, then compare both DUTs just after it.
   always begin
      @(posedge clk);
      if (!rst_n) begin
         rst_edge = ec;
         lfsr_m   = 16'hACE1;
      end else if (ec < MAXE) begin
         acc_h[ec]  = mem_re && !busy_of(lfsr_m);
         addr_h[ec] = mem_raddr;
         data_h[ec] = ref_mem[mem_raddr[9:0]];
         fl_h[ec]   = flush;
         if (mem_we) ref_mem[mem_waddr[9:0]] = mem_wdata;
         lfsr_m = lfsr_next(lfsr_m);
         ec++;
      end
      #1;
      if (!rst_n) begin
         chk("rst.ready1", 32'(rdy1), 32'd0);
         chk("rst.ready3", 32'(rdy3), 32'd0);
         chk("rst.addr3",  32'(ao3),  32'd0);
         chk("rst.data3",  32'(do3),  32'd0);
      end else if (ec > 0) begin
         chk_port("L1", 1, ec - 1, rdy1, ao1, do1);
         chk_port("L3", 3, ec - 1, rdy3, ao3, do3);
         chk("busy1", 32'(busy1), 32'(busy_of(lfsr_m)));
         chk("busy3", 32'(busy3), 32'(busy_of(lfsr_m)));
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [15:0] val(input int i);
      if (i == 5) return 16'h1234;
      if (i == 7) return 16'h7777;
      return 16'(i * 257) ^ 16'h5A00;
   endfunction

   task automatic drive(input logic re, input logic [15:0] ra, input logic fl,
                        input logic we, input logic [15:0] wa, input logic [15:0] wd);
      @(negedge clk);
      mem_re = re; mem_raddr = ra; flush = fl;
      mem_we = we; mem_waddr = wa; mem_wdata = wd;
      @(posedge clk);
      #2;
   endtask

   task automatic rd(input logic [15:0] ra);
      drive(1'b1, ra, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic idle();
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0;
      rst_n = 1'b0; mem_re = 1'b0; mem_raddr = '0; flush = 1'b0;
      mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset.addr1", 32'(ao1),   32'd0);
      chk("reset.data1", 32'(do1),   32'd0);
      chk("reset.busy1", 32'(busy1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // program load
      for (int i = 0; i < 64; i++) drive(1'b0, 16'h0, 1'b0, 1'b1, 16'(i), val(i));
      idle();

`ifndef IMEM_STALL_INJECT_EN
      // single read: L1 responds next cycle, L3 two cycles after that
      rd(16'd5);
      chk("t1.l1.ready", 32'(rdy1), 32'd1);
      chk("t1.l1.addr",  32'(ao1),  32'h5);
      chk("t1.l1.data",  32'(do1),  32'h1234);
      idle();
      idle();
      chk("t1.l3.ready", 32'(rdy3), 32'd1);
      chk("t1.l3.data",  32'(do3),  32'h1234);
      idle();

      // back-to-back burst on L3
      rd(16'd0); rd(16'd1);
      chk("t2.early", 32'(rdy3), 32'd0);
      rd(16'd2);
      chk("t2.a0", 32'(ao3), 32'h0);
      chk("t2.r0", 32'(rdy3), 32'd1);
      idle();
      chk("t2.a1", 32'(ao3), 32'h1);
      idle();
      chk("t2.a2", 32'(ao3), 32'h2);
      idle();
      chk("t2.end", 32'(rdy3), 32'd0);

      // read/write collision
      drive(1'b1, 16'd7, 1'b0, 1'b1, 16'd7, 16'hBEEF);
      chk("t3.old", 32'(do1), 32'h7777);
      rd(16'd7);
      chk("t3.new", 32'(do1), 32'hBEEF);
      idle(); idle(); idle();

      // flush with redirect (L3: request 10 already out before the flush)
      rd(16'd10); rd(16'd11); rd(16'd12);
      chk("t4.r10", 32'(ao3), 32'd10);
      drive(1'b1, 16'd40, 1'b1, 1'b0, 16'h0, 16'h0);
      chk("t4.kill11", 32'(rdy3), 32'd0);
      chk("t4.l1.40",  32'(ao1),  32'd40);
      idle();
      chk("t4.kill12", 32'(rdy3), 32'd0);
      idle();
      chk("t4.r40",  32'(rdy3), 32'd1);
      chk("t4.a40",  32'(ao3),  32'd40);
      idle();
      chk("t4.once", 32'(rdy3), 32'd0);

      // address aliasing
      rd(16'h0405);
      chk("t5.addr", 32'(ao1), 32'h0405);
      chk("t5.data", 32'(do1), 32'h1234);
      idle();
`endif

      // reset mid-operation: nothing in flight may survive
      rd(16'd20); rd(16'd21);
      @(negedge clk);
      rst_n = 1'b0; mem_re = 1'b1; mem_raddr = 16'd22;
      #1;
      chk("t6.rst.ready3", 32'(rdy3), 32'd0);
      chk("t6.rst.addr3",  32'(ao3),  32'd0);
      @(negedge clk);
      rst_n = 1'b1; mem_re = 1'b0;
      rd(16'd30);
`ifndef IMEM_STALL_INJECT_EN
      chk("t6.after", 32'(ao1), 32'd30);
`endif
      idle(); idle(); idle();

      // random traffic, all checked by the model
      for (int n = 0; n < 1000; n++) begin
         drive($urandom_range(0, 3) != 0, 16'($urandom) & 16'hFC3F,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 5) == 0, 16'($urandom) & 16'h003F, 16'($urandom));
      end
      repeat (5) idle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
